// File: rtl/ita_requantizer_pipe_if.sv
// Beat handshake, per-set requant constants and output bus of the requantizer.
// The slave view belongs to the pipeline and the master view to whoever feeds and drains it.
interface ita_requantizer_pipe_if #(
  parameter int N   = 16,
  parameter int WO  = 26,
  parameter int WI  = 8,
  parameter int EMS = 8,
  parameter int NC  = 6
);
  logic                valid_i;
  logic                ready_o;
  logic [N*WO-1:0]     data_i;
  logic [2:0]          const_idx_i;
  logic [NC*EMS-1:0]   eps_mult_i;
  logic [NC*EMS-1:0]   right_shift_i;
  logic [NC*WI-1:0]    add_i;
  logic                valid_o;
  logic                ready_i;
  logic [N*WI-1:0]     data_o;
  logic [15:0]         beat_cnt_o;

  modport slave (
    input  valid_i, data_i, const_idx_i, eps_mult_i, right_shift_i, add_i, ready_i,
    output ready_o, valid_o, data_o, beat_cnt_o
  );

  modport master (
    output valid_i, data_i, const_idx_i, eps_mult_i, right_shift_i, add_i, ready_i,
    input  ready_o, valid_o, data_o, beat_cnt_o
  );
endinterface

// File: rtl/ita_requantizer_pipe.sv
// Three-stage requantizer: multiply, round+shift, offset+saturate, with one global advance enable.
// Constants are captured with each accepted beat so later changes never touch beats in flight.
module ita_requantizer_pipe #(
  parameter int N   = 16,
  parameter int WO  = 26,
  parameter int WI  = 8,
  parameter int EMS = 8,
  parameter int NC  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  ita_requantizer_pipe_if.slave bus
);
  localparam int WP = WO + EMS + 1;
  localparam int WS = WP + 1;
  localparam logic signed [WS-1:0] SAT_HI = WS'((64'sd1 <<< (WI - 1)) - 64'sd1);
  localparam logic signed [WS-1:0] SAT_LO = ~SAT_HI;

  typedef logic signed [WP-1:0] prod_t;

  logic                  adv_s;
  logic                  accept_s;
  logic [2:0]            sel_s;
  logic [EMS-1:0]        mult_sel_s;
  logic [EMS-1:0]        shift_sel_s;
  logic signed [WI-1:0]  add_sel_s;

  logic                  v1_r;
  logic                  v2_r;
  logic                  valid_o_r;
  prod_t                 p1_r [N];
  logic [EMS-1:0]        sh1_r;
  logic signed [WI-1:0]  add1_r;
  prod_t                 r2_r [N];
  logic signed [WI-1:0]  add2_r;
  logic [N*WI-1:0]       data_o_r;
  logic [15:0]           cnt_r;

  // Shifts of 32 or more collapse to the sign; the extra bit keeps the rounding bias from overflowing.
  function automatic prod_t round_shift(input prod_t p, input logic [EMS-1:0] sh);
    logic signed [WS-1:0] ext;
    logic signed [WS-1:0] bias;
    logic signed [WS-1:0] shifted;
    ext = {p[WP-1], p};
    if (sh == '0) begin
      return p;
    end else if (32'(sh) >= 32'd32) begin
      return p[WP-1] ? '1 : '0;
    end else begin
      bias    = {{(WS-1){1'b0}}, 1'b1} << (sh - {{(EMS-1){1'b0}}, 1'b1});
      shifted = (ext + bias) >>> sh;
      return shifted[WP-1:0];
    end
  endfunction

  function automatic logic signed [WI-1:0] saturate(input prod_t r, input logic signed [WI-1:0] a);
    logic signed [WS-1:0] s;
    s = {r[WP-1], r} + {{(WS-WI){a[WI-1]}}, a};
    if (s > SAT_HI) begin
      return SAT_HI[WI-1:0];
    end else if (s < SAT_LO) begin
      return SAT_LO[WI-1:0];
    end else begin
      return s[WI-1:0];
    end
  endfunction

  assign adv_s          = !valid_o_r || bus.ready_i;
  assign accept_s       = bus.valid_i && adv_s && !flush_i;
  assign bus.ready_o    = adv_s && !flush_i;
  assign bus.valid_o    = valid_o_r;
  assign bus.data_o     = data_o_r;
  assign bus.beat_cnt_o = cnt_r;

  // Constant-set select; out-of-range indices fall back to set 0.
  always_comb begin
    if (32'(bus.const_idx_i) < NC) begin
      sel_s = bus.const_idx_i;
    end else begin
      sel_s = 3'd0;
    end
    mult_sel_s  = bus.eps_mult_i[32'(sel_s)*EMS +: EMS];
    shift_sel_s = bus.right_shift_i[32'(sel_s)*EMS +: EMS];
    add_sel_s   = $signed(bus.add_i[32'(sel_s)*WI +: WI]);
  end

  // Stage valid bits and delivered-beat counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      valid_o_r <= 1'b0;
      cnt_r     <= 16'd0;
    end else begin
      if (flush_i) begin
        v1_r      <= 1'b0;
        v2_r      <= 1'b0;
        valid_o_r <= 1'b0;
      end else if (adv_s) begin
        v1_r      <= accept_s;
        v2_r      <= v1_r;
        valid_o_r <= v2_r;
      end
      if (valid_o_r && bus.ready_i) begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

  // Datapath registers; everything holds while the pipeline is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N; k++) begin
        p1_r[k] <= '0;
        r2_r[k] <= '0;
      end
      sh1_r    <= '0;
      add1_r   <= '0;
      add2_r   <= '0;
      data_o_r <= '0;
    end else if (adv_s) begin
      for (int k = 0; k < N; k++) begin
        p1_r[k] <= WP'($signed(bus.data_i[k*WO +: WO])) * WP'($signed({1'b0, mult_sel_s}));
        r2_r[k] <= round_shift(p1_r[k], sh1_r);
        data_o_r[k*WI +: WI] <= saturate(r2_r[k], add2_r);
      end
      sh1_r  <= shift_sel_s;
      add1_r <= add_sel_s;
      add2_r <= add1_r;
    end
  end
endmodule

// File: tb/tb_ita_requantizer_pipe.sv
// Directed bench for the requantizer with a queue-based arithmetic model and per-cycle checker.
module tb_ita_requantizer_pipe;
  localparam int N = 16, WO = 26, WI = 8, EMS = 8, NC = 6;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0;

  ita_requantizer_pipe_if #(.N(N), .WO(WO), .WI(WI), .EMS(EMS), .NC(NC)) bus();
  ita_requantizer_pipe #(.N(N), .WO(WO), .WI(WI), .EMS(EMS), .NC(NC)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .bus(bus));

  always #5 clk = ~clk;

  longint lane [N];
  int     mult_c [NC];
  int     sh_c [NC];
  int     add_c [NC];
  int     total = 0;
  int     bad = 0;
  logic [N*WI-1:0] expq [$];
  logic [15:0]     mcnt = 16'd0;
  logic            prev_hold = 1'b0;
  logic [N*WI-1:0] prev_data = '0;

  always_comb begin
    bus.data_i = '0;
    bus.eps_mult_i = '0;
    bus.right_shift_i = '0;
    bus.add_i = '0;
    for (int k = 0; k < N; k++) bus.data_i[k*WO +: WO] = WO'(lane[k]);
    for (int i = 0; i < NC; i++) begin
      bus.eps_mult_i[i*EMS +: EMS]    = EMS'(mult_c[i]);
      bus.right_shift_i[i*EMS +: EMS] = EMS'(sh_c[i]);
      bus.add_i[i*WI +: WI]           = WI'(add_c[i]);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Requantization from the arithmetic definition: floor division with a half-step bias.
  function automatic longint requant(input longint x, input longint m, input longint sh, input longint a);
    longint p, r, d, num, s, hi;
    p = x * m;
    if (sh == 0) r = p;
    else if (sh >= 32) r = (p < 0) ? -1 : 0;
    else begin
      d = 64'sd1 <<< sh;
      num = p + d / 2;
      r = num / d;
      if ((num % d != 0) && (num < 0)) r = r - 1;
    end
    s = r + a;
    hi = (64'sd1 <<< (WI - 1)) - 1;
    if (s > hi) s = hi;
    if (s < -hi - 1) s = -hi - 1;
    return s;
  endfunction

  function automatic logic [N*WI-1:0] expected_beat(input int idx);
    logic [N*WI-1:0] e;
    int s;
    s = (idx < NC) ? idx : 0;
    for (int k = 0; k < N; k++)
      e[k*WI +: WI] = WI'(requant(lane[k], longint'(mult_c[s]), longint'(sh_c[s]), longint'(add_c[s])));
    return e;
  endfunction

  function automatic longint lane_out(input int k);
    return longint'($signed(bus.data_o[k*WI +: WI]));
  endfunction

  // Per-cycle checker: handshake rules, stall stability, counter and beat contents against the model.
  always @(negedge clk) begin
    if (!rst_ni) begin
      expq.delete();
      mcnt = 16'd0;
      prev_hold = 1'b0;
      check("rst_valid_o", longint'(bus.valid_o), 0);
      check("rst_data_o", longint'(bus.data_o != '0), 0);
      check("rst_beat_cnt", longint'(bus.beat_cnt_o), 0);
      check("rst_ready_o", longint'(bus.ready_o), 1);
    end else begin
      check("ready_o", longint'(bus.ready_o), longint'((!bus.valid_o || bus.ready_i) && !flush_i));
      check("beat_cnt", longint'(bus.beat_cnt_o), longint'(mcnt));
      if (prev_hold) begin
        total++;
        if (!bus.valid_o || bus.data_o !== prev_data) begin
          bad++;
          $display("FAIL stall_hold: got v=%0b d=%h expected v=1 d=%h", bus.valid_o, bus.data_o, prev_data);
        end
      end
      if (bus.valid_o && bus.ready_i) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got d=%h expected no beat", bus.data_o);
        end else begin
          logic [N*WI-1:0] e;
          e = expq.pop_front();
          if (bus.data_o !== e) begin
            bad++;
            $display("FAIL beat_data: got %h expected %h", bus.data_o, e);
          end
        end
        mcnt = mcnt + 16'd1;
      end
      if (flush_i) expq.delete();
      else if (bus.valid_i && bus.ready_o) expq.push_back(expected_beat(int'(bus.const_idx_i)));
      prev_hold = bus.valid_o && !bus.ready_i && !flush_i;
      prev_data = bus.data_o;
    end
  end

  task automatic send(input int idx);
    int g;
    bus.valid_i = 1'b1;
    bus.const_idx_i = 3'(idx);
    g = 0;
    @(negedge clk);
    while (!bus.ready_o && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.ready_o) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready_o=0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.valid_o && lat < 20);
  endtask

  task automatic set_c(input int i, input int m, input int sh, input int a);
    mult_c[i] = m;
    sh_c[i] = sh;
    add_c[i] = a;
  endtask

  task automatic clear_lanes();
    for (int k = 0; k < N; k++) lane[k] = 0;
  endtask

  task automatic rand_lanes();
    for (int k = 0; k < N; k++)
      lane[k] = longint'($urandom_range(0, 67108863)) - 64'sd33554432;
  endtask

  initial begin
    int lat;
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    bus.const_idx_i = 3'd0;
    clear_lanes();
    for (int i = 0; i < NC; i++) set_c(i, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    bus.valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Basic value and latency
    set_c(0, 128, 7, -3);
    rand_lanes();
    lane[0] = 100;
    send(0);
    wait_out(lat);
    check("latency", lat, 3);
    check("lane_97", lane_out(0), 97);

    // Rounding
    set_c(1, 1, 1, 0);
    clear_lanes();
    lane[0] = 3;
    lane[1] = -3;
    send(1);
    wait_out(lat);
    check("round_pos", lane_out(0), 2);
    check("round_neg", lane_out(1), -1);

    // Saturation both ways
    set_c(3, 64, 0, 0);
    set_c(4, 255, 0, 0);
    lane[0] = 1000;
    send(3);
    wait_out(lat);
    check("sat_hi", lane_out(0), 127);
    lane[0] = -100000;
    send(4);
    wait_out(lat);
    check("sat_lo", lane_out(0), -128);

    // Large shifts collapse to the sign
    set_c(5, 200, 40, 3);
    lane[0] = 5;
    lane[1] = -5;
    send(5);
    wait_out(lat);
    check("bigshift_pos", lane_out(0), 3);
    check("bigshift_neg", lane_out(1), 2);

    // Back-to-back stream over every set and out-of-range indices
    set_c(0, 128, 7, -3);
    set_c(1, 1, 1, 0);
    set_c(2, 255, 12, 10);
    set_c(3, 64, 0, 0);
    set_c(4, 255, 31, -1);
    set_c(5, 200, 40, 3);
    for (int b = 0; b < 16; b++) begin
      rand_lanes();
      send(b % 8);
    end
    repeat (6) @(posedge clk);
    #1;

    // Set selection and capture at acceptance
    set_c(2, 3, 0, 5);
    set_c(0, 2, 0, 0);
    clear_lanes();
    lane[0] = 10;
    send(2);
    set_c(2, 100, 0, -7);
    wait_out(lat);
    check("set2_captured", lane_out(0), 35);
    send(7);
    wait_out(lat);
    check("idx7_set0", lane_out(0), 20);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure with a fresh counter
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    fork
      begin
        for (int b = 0; b < 5; b++) begin
          rand_lanes();
          send(b);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_ready_o", longint'(bus.ready_o), 0);
        repeat (2) @(posedge clk);
        #1;
        bus.ready_i = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("bp_cnt", longint'(bus.beat_cnt_o), 5);
    check("bp_drained", longint'(expq.size()), 0);
    @(posedge clk);
    #1;

    // Flush with three beats in flight
    for (int b = 0; b < 3; b++) begin
      rand_lanes();
      send(0);
    end
    flush_i = 1'b1;
    bus.ready_i = 1'b0;
    @(negedge clk);
    check("flush_ready_o", longint'(bus.ready_o), 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    check("flush_valid_o", longint'(bus.valid_o), 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("flush_cnt", longint'(bus.beat_cnt_o), 5);
    @(posedge clk);
    #1;

    // Reset with three beats in flight, then a clean beat
    for (int b = 0; b < 3; b++) begin
      rand_lanes();
      send(2);
    end
    rst_ni = 1'b0;
    @(negedge clk);
    check("rst_mid_valid_o", longint'(bus.valid_o), 0);
    check("rst_mid_cnt", longint'(bus.beat_cnt_o), 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    clear_lanes();
    lane[0] = 3;
    lane[1] = -3;
    send(1);
    wait_out(lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_round", lane_out(1), -1);
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
